// File: rtl/state_log_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | state_log_pkg: shared constants, FSM encoding and frame helpers for        |
// | state_log_serial_tx.                            Revision: 1.0              |
// +----------------------------------------------------------------------------+
package state_log_pkg;

  localparam int         FRAME_LEN   = 21;
  localparam logic [3:0] HDR_DEFAULT = 4'hA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Even parity: the parity bit makes the total count of ones over data+parity even.
  function automatic logic parity16(input logic [15:0] data);
    return ^data;
  endfunction

  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [3:0]  hdr,
                                                       input logic [15:0] data);
    return {hdr, data, parity16(data)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_bit_timer: divides clk into low/high serial-clock phases and flags  |
// | the last cycle of each bit period.              Revision: 1.0              |
// +----------------------------------------------------------------------------+
module serial_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iRun,
  output logic oSclk,
  output logic oBitEnd
);

  generate
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("serial_bit_timer: CLK_DIV must be in 1..255");
    end
  endgenerate

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_phase;

  // Holding the counter cleared while idle guarantees every frame starts on a fresh low phase.
  always_ff @(posedge iClk) begin
    if (iRst || !iRun) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (r_div == c_div_last) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign oSclk   = r_phase;
  assign oBitEnd = iRun && r_phase && (r_div == c_div_last);

endmodule
`default_nettype wire

// File: rtl/state_log_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | state_log_serial_tx: snapshots the four logged state nibbles and shifts    |
// | them out as a framed serial word, optionally clearing the logger after.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module state_log_serial_tx
  import state_log_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter int         CLR_ON_READ = 1,
  parameter logic [3:0] HDR         = HDR_DEFAULT
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iReq,
  input  logic [3:0] iPrev0,
  input  logic [3:0] iPrev1,
  input  logic [3:0] iPrev2,
  input  logic [3:0] iCur,
  output logic       oBusy,
  output logic       oFrame,
  output logic       oSclk,
  output logic       oSdo,
  output logic       oDone,
  output logic       oClrLog
);

  localparam logic [4:0] c_last_bit = 5'(FRAME_LEN - 1);
  localparam logic       c_clr_en   = (CLR_ON_READ != 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [4:0]             r_bit_cnt;
  logic                   w_run;
  logic                   w_sclk;
  logic                   w_bit_end;
  logic                   w_accept;

  assign w_run    = (r_state == SHIFT);
  assign w_accept = (r_state == IDLE) && iReq;

  serial_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .iClk    (iClk),
    .iRst    (iRst),
    .iRun    (w_run),
    .oSclk   (w_sclk),
    .oBitEnd (w_bit_end)
  );

  assign oSclk = w_sclk;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    oBusy       = 1'b0;
    oFrame      = 1'b0;
    oSdo        = 1'b0;
    oDone       = 1'b0;
    oClrLog     = 1'b0;
    case (r_state)
      IDLE: begin
        if (iReq) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        oBusy  = 1'b1;
        oFrame = 1'b1;
        oSdo   = r_shift[FRAME_LEN-1];
        if (w_bit_end && (r_bit_cnt == c_last_bit)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        oBusy       = 1'b1;
        oDone       = 1'b1;
        oClrLog     = c_clr_en;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The shift register only moves at bit ends, which are also the only points where oSdo may change.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= build_frame(HDR, {iPrev0, iPrev1, iPrev2, iCur});
      r_bit_cnt <= '0;
    end else if (w_run && w_bit_end) begin
      r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
      if (r_bit_cnt == c_last_bit) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_state_log_serial_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_state_log_serial_tx: scoreboard bench for two instances (CLK_DIV=4 with |
// | clear-on-read, CLK_DIV=1 without).              Revision: 1.0              |
// +----------------------------------------------------------------------------+
module tb_state_log_serial_tx;

  typedef struct {
    int          dut;
    logic [20:0] frame;
    logic        clr;
  } exp_t;

  logic       clk;
  logic       rst  [2];
  logic       req  [2];
  logic [3:0] prv0 [2];
  logic [3:0] prv1 [2];
  logic [3:0] prv2 [2];
  logic [3:0] cur  [2];
  logic       busy [2];
  logic       frm  [2];
  logic       sclk [2];
  logic       sdo  [2];
  logic       done [2];
  logic       clr  [2];

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  int          c_div [2] = '{4, 1};
  logic [20:0] cap   [2];
  int          nbits [2];
  int          fcyc  [2];
  logic        p_sclk[2];
  logic        p_frm [2];
  logic        p_done[2];

  state_log_serial_tx #(.CLK_DIV(4), .CLR_ON_READ(1), .HDR(4'hA)) u_dut0 (
    .iClk(clk), .iRst(rst[0]), .iReq(req[0]),
    .iPrev0(prv0[0]), .iPrev1(prv1[0]), .iPrev2(prv2[0]), .iCur(cur[0]),
    .oBusy(busy[0]), .oFrame(frm[0]), .oSclk(sclk[0]), .oSdo(sdo[0]),
    .oDone(done[0]), .oClrLog(clr[0])
  );

  state_log_serial_tx #(.CLK_DIV(1), .CLR_ON_READ(0), .HDR(4'hA)) u_dut1 (
    .iClk(clk), .iRst(rst[1]), .iReq(req[1]),
    .iPrev0(prv0[1]), .iPrev1(prv1[1]), .iPrev2(prv2[1]), .iCur(cur[1]),
    .oBusy(busy[1]), .oFrame(frm[1]), .oSclk(sclk[1]), .oSdo(sdo[1]),
    .oDone(done[1]), .oClrLog(clr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: reassembles each frame from rising oSclk and compares at oDone.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (frm[d] && !p_frm[d]) begin
        cap[d] = '0; nbits[d] = 0; fcyc[d] = 0;
      end
      if (frm[d]) fcyc[d]++;
      if (frm[d] && sclk[d] && !p_sclk[d]) begin
        cap[d] = {cap[d][19:0], sdo[d]};
        nbits[d]++;
      end
      if (p_done[d]) chk("busy_after_done", 32'(busy[d]), 32'd0);
      if (clr[d] && !done[d]) chk("clr_without_done", 32'(clr[d]), 32'd0);
      if (done[d]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done[d]), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_dut_id", 32'(d), 32'(e.dut));
          chk("frame_bits", 32'(cap[d]), 32'(e.frame));
          chk("frame_nbits", 32'(nbits[d]), 32'd21);
          chk("frame_cycles", 32'(fcyc[d]), 32'(42 * c_div[d]));
          chk("clr_at_done", 32'(clr[d]), 32'(e.clr));
          chk("busy_at_done", 32'(busy[d]), 32'd1);
        end
      end
      p_sclk[d] = sclk[d];
      p_frm[d]  = frm[d];
      p_done[d] = done[d];
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_in(input int d, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] e);
    prv0[d] = a; prv1[d] = b; prv2[d] = c; cur[d] = e;
  endtask

  task automatic push(input int d, input logic [20:0] f, input logic c);
    exp_t e;
    e.dut = d; e.frame = f; e.clr = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req(input int d);
    req[d] = 1'b1;
    tick(1);
    req[d] = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle; an expired budget counts as a failure.
  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (!done[d] && n < budget) begin
      tick(1);
      n++;
    end
    if (!done[d]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [20:0] vec_frame [3] = '{{4'hA, 16'h0000, 1'b0}, {4'hA, 16'hFFFF, 1'b0}, {4'hA, 16'h0001, 1'b1}};
  logic [15:0] vec_data  [3] = '{16'h0000, 16'hFFFF, 16'h0001};

  initial begin
    int gap;
    logic [3:0] sc;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0;
      set_in(d, 4'h0, 4'h0, 4'h0, 4'h0);
      p_sclk[d] = 1'b0; p_frm[d] = 1'b0; p_done[d] = 1'b0;
      cap[d] = '0; nbits[d] = 0; fcyc[d] = 0;
    end
    tick(3);
    chk("reset_outputs", 32'({busy[0], frm[0], sclk[0], sdo[0], done[0], clr[0]}), 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick(2);

    // Basic frame 1,2,3,4
    set_in(0, 4'h1, 4'h2, 4'h3, 4'h4);
    push(0, {4'hA, 16'h1234, 1'b1}, 1'b1);
    pulse_req(0);
    chk("accept_outputs", 32'({busy[0], frm[0], sclk[0], sdo[0]}), 32'b1101);
    wait_done(0, 400);
    tick(2);

    // Parity corner vectors
    for (int v = 0; v < 3; v++) begin
      set_in(0, vec_data[v][15:12], vec_data[v][11:8], vec_data[v][7:4], vec_data[v][3:0]);
      push(0, vec_frame[v], 1'b1);
      pulse_req(0);
      wait_done(0, 400);
      tick(2);
    end

    // Mid-frame request and input change are ignored
    set_in(0, 4'h1, 4'h2, 4'h3, 4'h4);
    push(0, {4'hA, 16'h1234, 1'b1}, 1'b1);
    pulse_req(0);
    tick(30);
    set_in(0, 4'h9, 4'h9, 4'h9, 4'h9);
    pulse_req(0);
    wait_done(0, 400);
    tick(20);
    chk("no_second_frame", 32'({busy[0], frm[0]}), 32'd0);

    // Level-held request: back-to-back frames, each snapshotting at its own start
    set_in(0, 4'h5, 4'h6, 4'h7, 4'h8);
    push(0, {4'hA, 16'h5678, 1'b0}, 1'b1);
    req[0] = 1'b1;
    tick(20);
    set_in(0, 4'h0, 4'h0, 4'h0, 4'h1);
    push(0, {4'hA, 16'h0001, 1'b1}, 1'b1);
    wait_done(0, 400);
    gap = 0;
    while (!frm[0] && gap < 10) begin
      tick(1);
      gap++;
    end
    chk("b2b_gap", 32'(gap), 32'd2);
    req[0] = 1'b0;
    wait_done(0, 400);
    tick(10);
    chk("no_third_frame", 32'({busy[0], frm[0]}), 32'd0);

    // Reset mid-frame aborts without done/clear
    set_in(0, 4'h1, 4'h2, 4'h3, 4'h4);
    pulse_req(0);
    tick(49);
    rst[0] = 1'b1;
    tick(1);
    chk("abort_outputs", 32'({busy[0], frm[0], sclk[0], sdo[0], done[0], clr[0]}), 32'd0);
    rst[0] = 1'b0;
    tick(5);
    set_in(0, 4'h4, 4'h3, 4'h2, 4'h1);
    push(0, {4'hA, 16'h4321, 1'b1}, 1'b1);
    pulse_req(0);
    wait_done(0, 400);
    tick(2);

    // CLK_DIV=1, no clear-on-read
    set_in(1, 4'h1, 4'h2, 4'h3, 4'h4);
    push(1, {4'hA, 16'h1234, 1'b1}, 1'b0);
    pulse_req(1);
    sc = '0;
    for (int i = 0; i < 4; i++) begin
      sc = {sc[2:0], sclk[1]};
      if (i < 3) tick(1);
    end
    chk("div1_sclk_toggle", 32'(sc), 32'b0101);
    wait_done(1, 200);
    tick(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
